// File: rtl/reg_list_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : reg_list_sequencer_if
// Brief    : Request and micro-op bus between decode, the register-list
//            sequencer and the register-read/memory stages.
// Revision : 1.0
// ============================================================================
interface reg_list_sequencer_if #(
    parameter int ADDR_WIDTH   = 4,
    parameter int LIST_WIDTH   = 8,
    parameter int OFFSET_WIDTH = 8
);
    logic                    start_i;
    logic                    ready_o;
    logic [1:0]              op_i;
    logic [LIST_WIDTH-1:0]   reg_list_i;
    logic                    extra_reg_i;
    logic [ADDR_WIDTH-1:0]   base_addr_i;
    logic                    stall_i;
    logic                    flush_i;
    logic                    uop_valid_o;
    logic                    uop_is_load_o;
    logic [ADDR_WIDTH-1:0]   uop_base_addr_o;
    logic [ADDR_WIDTH-1:0]   uop_reg_addr_o;
    logic [OFFSET_WIDTH-1:0] uop_offset_o;
    logic                    uop_last_o;
    logic                    wb_valid_o;
    logic [ADDR_WIDTH-1:0]   wb_addr_o;
    logic [OFFSET_WIDTH-1:0] wb_offset_o;
    logic                    busy_o;

    modport master (
        output start_i, op_i, reg_list_i, extra_reg_i, base_addr_i, stall_i, flush_i,
        input  ready_o, uop_valid_o, uop_is_load_o, uop_base_addr_o, uop_reg_addr_o,
               uop_offset_o, uop_last_o, wb_valid_o, wb_addr_o, wb_offset_o, busy_o
    );

    modport slave (
        input  start_i, op_i, reg_list_i, extra_reg_i, base_addr_i, stall_i, flush_i,
        output ready_o, uop_valid_o, uop_is_load_o, uop_base_addr_o, uop_reg_addr_o,
               uop_offset_o, uop_last_o, wb_valid_o, wb_addr_o, wb_offset_o, busy_o
    );
endinterface
`default_nettype wire

// File: rtl/reg_list_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : reg_list_sequencer
// Brief    : Expands PUSH/POP/LDM!/STM! register lists into one transfer
//            micro-op per register followed by a base write-back micro-op.
// Revision : 1.0
// ============================================================================
module reg_list_sequencer #(
    parameter int ADDR_WIDTH   = 4,
    parameter int LIST_WIDTH   = 8,
    parameter int OFFSET_WIDTH = 8,
    parameter int WORD_BYTES   = 4,
    parameter int SP_REG_NUM   = 13
) (
    input  wire logic              clk_i,
    input  wire logic              rst_n_i,
    reg_list_sequencer_if.slave    bus
);
    localparam int MASK_W = LIST_WIDTH + 1;
    localparam int CNT_W  = $clog2(MASK_W + 1);

    localparam logic [1:0] c_op_ldm  = 2'b01;
    localparam logic [1:0] c_op_push = 2'b10;
    localparam logic [1:0] c_op_pop  = 2'b11;

    localparam logic [ADDR_WIDTH-1:0]   c_sp_reg = ADDR_WIDTH'(SP_REG_NUM);
    localparam logic [ADDR_WIDTH-1:0]   c_lr_reg = ADDR_WIDTH'(14);
    localparam logic [ADDR_WIDTH-1:0]   c_pc_reg = ADDR_WIDTH'(15);
    localparam logic [OFFSET_WIDTH-1:0] c_word   = OFFSET_WIDTH'(WORD_BYTES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t                  r_state;
    logic [1:0]              r_op;
    logic [MASK_W-1:0]       r_mask;
    logic [ADDR_WIDTH-1:0]   r_base;
    logic [OFFSET_WIDTH-1:0] r_offset;
    logic [OFFSET_WIDTH-1:0] r_wb_offset;
    logic                    r_wb_en;

    logic [MASK_W-1:0]       w_mask_in;
    logic [CNT_W-1:0]        w_n;
    logic [OFFSET_WIDTH-1:0] w_span;
    logic                    w_base_listed;
    logic [ADDR_WIDTH-1:0]   w_reg_addr;
    logic                    w_last;
    logic                    w_xfer;
    logic                    w_wb;

    // Bit 8 carries LR/PC and only exists for PUSH/POP.
    assign w_mask_in = {bus.extra_reg_i & bus.op_i[1], bus.reg_list_i};

    always_comb begin
        w_n = '0;
        for (int i = 0; i < MASK_W; i++) begin
            w_n = w_n + CNT_W'(w_mask_in[i]);
        end
    end

    assign w_span = OFFSET_WIDTH'(w_n) * c_word;

    always_comb begin
        w_base_listed = 1'b0;
        for (int i = 0; i < LIST_WIDTH; i++) begin
            if (bus.base_addr_i == ADDR_WIDTH'(i)) begin
                w_base_listed = bus.reg_list_i[i];
            end
        end
    end

    // Lowest set bit wins: scanning downward leaves the lowest index last.
    always_comb begin
        w_reg_addr = '0;
        for (int i = MASK_W - 1; i >= 0; i--) begin
            if (r_mask[i]) begin
                if (i == LIST_WIDTH) begin
                    w_reg_addr = (r_op == c_op_pop) ? c_pc_reg : c_lr_reg;
                end else begin
                    w_reg_addr = ADDR_WIDTH'(i);
                end
            end
        end
    end

    assign w_last = ((r_mask & (r_mask - MASK_W'(1))) == '0);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= S_IDLE;
            r_op        <= '0;
            r_mask      <= '0;
            r_base      <= '0;
            r_offset    <= '0;
            r_wb_offset <= '0;
            r_wb_en     <= 1'b0;
        end else if (bus.flush_i) begin
            r_state <= S_IDLE;
            r_mask  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start_i && (w_n != '0)) begin
                        r_state     <= S_XFER;
                        r_op        <= bus.op_i;
                        r_mask      <= w_mask_in;
                        r_base      <= bus.op_i[1] ? c_sp_reg : bus.base_addr_i;
                        r_offset    <= (bus.op_i == c_op_push) ? -w_span : '0;
                        r_wb_offset <= (bus.op_i == c_op_push) ? -w_span : w_span;
                        // LDM that reloads its own base keeps the loaded value.
                        r_wb_en     <= !((bus.op_i == c_op_ldm) && w_base_listed);
                    end
                end
                S_XFER: begin
                    if (!bus.stall_i) begin
                        r_mask   <= r_mask & (r_mask - MASK_W'(1));
                        r_offset <= r_offset + c_word;
                        if (w_last) begin
                            r_state <= r_wb_en ? S_WB : S_IDLE;
                        end
                    end
                end
                S_WB: begin
                    if (!bus.stall_i) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_xfer = (r_state == S_XFER);
    assign w_wb   = (r_state == S_WB);

    assign bus.ready_o         = (r_state == S_IDLE);
    assign bus.busy_o          = (r_state != S_IDLE);
    assign bus.uop_valid_o     = w_xfer;
    assign bus.uop_is_load_o   = w_xfer & r_op[0];
    assign bus.uop_base_addr_o = w_xfer ? r_base : '0;
    assign bus.uop_reg_addr_o  = w_xfer ? w_reg_addr : '0;
    assign bus.uop_offset_o    = w_xfer ? r_offset : '0;
    assign bus.uop_last_o      = w_xfer & w_last;
    assign bus.wb_valid_o      = w_wb;
    assign bus.wb_addr_o       = w_wb ? r_base : '0;
    assign bus.wb_offset_o     = w_wb ? r_wb_offset : '0;
endmodule
`default_nettype wire

// File: doc/reg_list_sequencer.md
Name: reg_list_sequencer

Overview:
- Micro-op expander for Thumb multi-register transfers: PUSH, POP, LDM Rn!, STM Rn!.
- Decode supplies only the base register. This block converts the latched register-list bitmask into one register-address micro-op per transfer, followed by a single base write-back micro-op.
- Sits between decode and the register-read/memory stages. Holds decode via busy_o while sequencing.

Parameters:
- ADDR_WIDTH, 4, register address width.
- LIST_WIDTH, 8, low-register list width (r0..r7).
- OFFSET_WIDTH, 8, signed byte-offset width.
- WORD_BYTES, 4, bytes per transfer.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset, asynchronous, active-low
- start_i  in  1  request valid
- ready_o  out  1  block idle; request accepted when start_i & ready_o
- op_i  in  2  00 STM, 01 LDM, 10 PUSH, 11 POP
- reg_list_i  in  LIST_WIDTH  register list, bit i = ri
- extra_reg_i  in  1  PUSH: include LR (r14); POP: include PC (r15); ignored for LDM/STM
- base_addr_i  in  ADDR_WIDTH  base Rn for LDM/STM; ignored for PUSH/POP (base = SP_REG_NUM)
- stall_i  in  1  downstream stall; holds the current micro-op
- flush_i  in  1  synchronous abort
- uop_valid_o  out  1  transfer micro-op valid
- uop_is_load_o  out  1  1 for LDM/POP
- uop_base_addr_o  out  ADDR_WIDTH  base register of the transfer
- uop_reg_addr_o  out  ADDR_WIDTH  data register of the transfer
- uop_offset_o  out  OFFSET_WIDTH  signed byte offset from base
- uop_last_o  out  1  final transfer micro-op
- wb_valid_o  out  1  base write-back micro-op valid
- wb_addr_o  out  ADDR_WIDTH  register written back
- wb_offset_o  out  OFFSET_WIDTH  signed byte offset added to base
- busy_o  out  1  not idle

Behaviour:
- Reset (async, rst_n_i=0): state IDLE; ready_o=1; all other outputs 0. Reset mid-sequence aborts immediately; no write-back is issued.
- States: IDLE, XFER, WB. All outputs are decoded from registered state (Moore); no input→output combinational paths except none.
- Accept in IDLE on start_i=1, regardless of stall_i. Latch the following:
  - op.
  - 9-bit mask {extra_reg_i & op[1], reg_list_i}; mask bit 8 maps to r14 for PUSH, r15 for POP.
  - Effective base: SP_REG_NUM for PUSH/POP, else base_addr_i.
  - n = popcount(mask).
- Empty mask (n=0): request accepted and dropped. Stay IDLE; no micro-ops, no write-back.
- XFER:
  - Emit one micro-op per cycle in ascending register order, selected by a lowest-set-bit priority encoder on the remaining mask.
  - The first micro-op is visible the cycle after accept.
  - Advance only when stall_i=0: clear the emitted bit, offset += WORD_BYTES. While stall_i=1 all uop outputs hold stable.
- Starting offset: PUSH = -WORD_BYTES*n; all others = 0. So PUSH stores the lowest register at the lowest address.
- uop_last_o=1 with the micro-op whose remaining mask has exactly one bit set.
- After the last micro-op advances:
  - Go to WB if write-back is required, else IDLE.
  - Write-back is suppressed only for LDM with base_addr_i < LIST_WIDTH and reg_list_i[base_addr_i]=1.
- WB:
  - wb_valid_o=1, wb_addr_o = effective base.
  - wb_offset_o = -WORD_BYTES*n for PUSH, +WORD_BYTES*n otherwise.
  - Held while stall_i=1. Goes to IDLE when stall_i=0.
- ready_o=1 only in IDLE; busy_o = ~ready_o. No back-to-back accept in the WB exit cycle.
- flush_i=1:
  - On the next edge, go to IDLE and deassert all valids.
  - Has priority over stall_i and over start_i in the same cycle (the request is not accepted).
- Width rules: max n=9 gives a max |offset| of 36, which fits OFFSET_WIDTH=8 signed. Offsets are two's complement.
- Cycle count, no stall: accept + n XFER cycles + 1 WB cycle (WB omitted when suppressed).

Test Plan:
- PUSH {r0,r2,LR} (op=10, list=0x05, extra=1): micro-ops (r0,-12), (r2,-8), (r14,-4,last), stores on base 13; then WB addr 13, offset -12; ready_o=1 on the 5th cycle after accept.
- POP {r1,PC} (op=11, list=0x02, extra=1): loads (r1,0), (r15,4,last); WB addr 13, offset +8.
- LDM r3!,{r3,r4} (op=01, base=3, list=0x18): loads (r3,0), (r4,4,last) on base 3; wb_valid_o never asserts; IDLE directly after the last micro-op.
- STM r0!,{r1} with stall_i=1 for 2 cycles on the micro-op: (r1,0,last) held stable for 3 cycles; then WB r0, +4 held during an additional 1-cycle stall.
- PUSH of list=0xFF, flush_i=1 after the 3rd micro-op: valids drop the next cycle, no WB; start_i asserted in the flush cycle is ignored; a new STM is accepted the following cycle.
- Empty list (list=0x00, extra=0): no valids, ready_o stays 1. Separately, assert rst_n_i=0 mid-POP: outputs clear asynchronously, no WB issued.
